// File: rtl/io_rx_fifo_port.sv
// CPU-facing receive FIFO on the Z8S180 I/O bus; pushes and pops commit on the falling edge of phi.
// Latency: a byte pushed at edge N appears on dout/irq after edge N and can be popped by the next rd_tick.
// Backpressure: none; a push into a full FIFO with no pop is dropped and sets sticky overrun.
module io_rx_fifo_port #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  phi,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  rd_tick,
    input  logic                  sel_data,
    input  logic                  sel_stat,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  irq
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overrun;
    logic                  r_underrun;

    logic       w_empty;
    logic       w_full;
    logic       w_do_pop;
    logic       w_do_push;
    logic       w_ovr_evt;
    logic       w_udr_evt;
    logic       w_clr;
    logic [5:0] w_lvl_ext;
    logic [4:0] w_lvl_sat;
    logic [7:0] w_status;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == L_DEPTH);
    assign w_do_pop  = rd_tick & sel_data & ~w_empty;
    assign w_do_push = push & (~w_full | w_do_pop);
    assign w_ovr_evt = push & w_full & ~w_do_pop;
    assign w_udr_evt = rd_tick & sel_data & w_empty;
    // Both selects asserted is treated as a data access, so the flags survive.
    assign w_clr     = rd_tick & sel_stat & ~sel_data;

    assign w_lvl_ext = 6'(r_level);
    assign w_lvl_sat = (w_lvl_ext > 6'd31) ? 5'd31 : w_lvl_ext[4:0];
    assign w_status  = {r_overrun, r_underrun, ~w_empty, w_lvl_sat};

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(negedge phi) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(negedge phi or negedge reset) begin
        if (!reset) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_level    <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A new error event on the clearing edge wins over the clear.
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (w_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_udr_evt) begin
                r_underrun <= 1'b1;
            end else if (w_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = '0;
        if (sel_data) begin
            if (!w_empty) begin
                dout = r_mem[r_rptr];
            end
        end else if (sel_stat) begin
            dout = WIDTH'(w_status);
        end
    end

    assign empty = w_empty;
    assign full  = w_full;
    assign level = r_level;
    assign irq   = ~w_empty;

endmodule

// File: tb/tb_io_rx_fifo_port.sv
// Directed bench for io_rx_fifo_port: ordering, full/empty boundaries, status flags, async reset, pointer wrap.
module tb_io_rx_fifo_port;

    logic       phi = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       rd_tick = 1'b0;
    logic       sel_data = 1'b0;
    logic       sel_stat = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       irq;

    int checks = 0;
    int errors = 0;

    io_rx_fifo_port #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .phi       (phi),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .rd_tick   (rd_tick),
        .sel_data  (sel_data),
        .sel_stat  (sel_stat),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .irq       (irq)
    );

    always #5 phi = ~phi;

    // One bus cycle: inputs applied after the rising edge, dout sampled
    // before the committing falling edge, inputs released after it.
    task automatic do_cycle(input logic p, input logic [7:0] d, input logic rt,
                            input logic sd, input logic ss, output logic [7:0] seen);
        @(posedge phi);
        #1;
        push = p; push_data = d; rd_tick = rt; sel_data = sd; sel_stat = ss;
        #2;
        seen = dout;
        @(negedge phi);
        #1;
        push = 1'b0; push_data = 8'h00; rd_tick = 1'b0; sel_data = 1'b0; sel_stat = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] seen;
        reset = 1'b0;
        repeat (2) @(posedge phi);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        reset = 1'b1;
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", seen); end
    endtask

    task automatic test_order();
        logic [7:0] seen;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) do_cycle(1'b1, exp_d[i], 1'b0, 1'b0, 1'b0, seen);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL order_level3: got %0d want 3", level); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL order_irq_hi: got %b want 1", irq); end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
            checks++; if (seen !== exp_d[i]) begin errors++; $display("FAIL order_data%0d: got %h want %h", i, seen, exp_d[i]); end
            checks++; if (level !== 5'(2 - i)) begin errors++; $display("FAIL order_level_after%0d: got %0d want %0d", i, level, 2 - i); end
            checks++; if (irq !== (i < 2)) begin errors++; $display("FAIL order_irq%0d: got %b want %b", i, irq, (i < 2)); end
        end
    endtask

    task automatic test_full_overrun();
        logic [7:0] seen;
        for (int i = 0; i < 17; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, seen);
            if (i == 15) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after16: got %b want 1", full); end
            end
        end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
        // Peek without rd_tick: overrun, non-empty, level 16.
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'hB0) begin errors++; $display("FAIL full_status_peek: got %h want b0", seen); end
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
            checks++; if (seen !== 8'(i)) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, seen, 8'(i)); end
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h80) begin errors++; $display("FAIL full_status_rd1: got %h want 80", seen); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL full_status_rd2: got %h want 00", seen); end
    endtask

    task automatic test_full_simul();
        logic [7:0] seen;
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, seen);
        do_cycle(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, seen);
        checks++; if (seen !== 8'h40) begin errors++; $display("FAIL simul_pop_data: got %h want 40", seen); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL simul_level: got %0d want 16", level); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h30) begin errors++; $display("FAIL simul_status: got %h want 30", seen); end
        for (int i = 1; i < 16; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
            checks++; if (seen !== 8'(8'h40 + i)) begin errors++; $display("FAIL simul_drain%0d: got %h want %h", i, seen, 8'(8'h40 + i)); end
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
        checks++; if (seen !== 8'hAA) begin errors++; $display("FAIL simul_last: got %h want aa", seen); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b want 1", empty); end
    endtask

    task automatic test_empty_read();
        logic [7:0] seen;
        do_cycle(1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, seen);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL empty_rd_dout: got %h want 00", seen); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL empty_rd_level: got %0d want 1", level); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h61) begin errors++; $display("FAIL empty_rd_status: got %h want 61", seen); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
        checks++; if (seen !== 8'h5C) begin errors++; $display("FAIL empty_rd_data: got %h want 5c", seen); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, seen);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL empty_rd_cleared: got %h want 00", seen); end
    endtask

    task automatic test_reset_mid_and_wrap();
        logic [7:0] seen;
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, seen);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL rst_pre_level: got %0d want 5", level); end
        @(posedge phi);
        #1;
        push = 1'b1; push_data = 8'hEE;
        #1;
        reset = 1'b0;
        #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_async_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b want 1", empty); end
        @(negedge phi);
        #1;
        push = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_held_level: got %0d want 0", level); end
        reset = 1'b1;
        do_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, seen);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
        checks++; if (seen !== 8'h77) begin errors++; $display("FAIL rst_after_data: got %h want 77", seen); end
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b1, 8'(i * 3 + 1), 1'b0, 1'b0, 1'b0, seen);
            do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, seen);
            checks++; if (seen !== 8'(i * 3 + 1)) begin errors++; $display("FAIL wrap%0d: got %h want %h", i, seen, 8'(i * 3 + 1)); end
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL wrap_level: got %0d want 0", level); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overrun();
        test_full_simul();
        test_empty_read();
        test_reset_mid_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
